// File: rtl/snn_window_scheduler_pkg.sv
// Shared types and default timing for the SNN window scheduler.
package snn_sched_pkg;
   typedef enum logic [2:0] {IDLE, CLEAR, ENCODE, INTEGRATE, SAMPLE, SCAN, RESULT} state_t;

   localparam int DEF_N_OUT         = 4;
   localparam int DEF_ENCODE_TIME   = 23;
   localparam int DEF_T_WINDOW      = 250;
   localparam int DEF_CNT_W         = 8;
   localparam int DEF_REFRAC_CYCLES = 50;

   typedef logic [DEF_CNT_W-1:0] spike_cnt_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/snn_window_scheduler_if.sv
// Handshake and neuron-array control bundle; slave = scheduler side, master = controller/array side.
interface snn_window_scheduler_if #(
   parameter int N_OUT = 4,
   parameter int CNT_W = 8
);
   localparam int IDX_W = $clog2(N_OUT);

   logic                start;
   logic [N_OUT-1:0]    out_spike;
   logic                neuron_rst;
   logic                enc_en;
   logic [N_OUT-1:0]    neuron_en;
   logic                busy;
   logic                result_valid;
   logic                result_ready;
   logic [IDX_W-1:0]    winner_idx;
   logic [CNT_W-1:0]    winner_cnt;
   logic                no_spike;

   modport slave (
      input  start, out_spike, result_ready,
      output neuron_rst, enc_en, neuron_en, busy, result_valid, winner_idx, winner_cnt, no_spike
   );

   modport master (
      output start, out_spike, result_ready,
      input  neuron_rst, enc_en, neuron_en, busy, result_valid, winner_idx, winner_cnt, no_spike
   );
endinterface

// File: rtl/snn_refrac_timer.sv
// Per-neuron refractory down-counter; mask reflects the count that will hold after this edge.
module snn_refrac_timer #(
   parameter int REFRAC_CYCLES = 50
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic load,
   input  logic tick,
   output logic mask
);
   localparam int W = $clog2(REFRAC_CYCLES + 1);

   logic [W-1:0] cnt, cnt_n;

   always_comb begin
      cnt_n = cnt;
      if (clear)                   cnt_n = '0;
      else if (load)               cnt_n = W'(REFRAC_CYCLES);
      else if (tick && cnt != '0)  cnt_n = cnt - 1'b1;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else     cnt <= cnt_n;

   // Look-ahead so the registered neuron_en lines up with the loaded count.
   assign mask = (cnt_n != '0);
endmodule

// File: rtl/snn_window_scheduler.sv
// One SNN classification window: clear, encode, integrate, count spikes, scan for argmax.
// Refractory masking is enabled with SNN_SCHED_REFRACTORY_EN.
module snn_window_scheduler
   import snn_sched_pkg::*;
#(
   parameter int N_OUT         = DEF_N_OUT,
   parameter int ENCODE_TIME   = DEF_ENCODE_TIME,
   parameter int T_WINDOW      = DEF_T_WINDOW,
   parameter int CNT_W         = DEF_CNT_W,
   parameter int REFRAC_CYCLES = DEF_REFRAC_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst,
   snn_window_scheduler_if.slave bus
);
   localparam int IDX_W = $clog2(N_OUT);
   localparam int WIN_W = $clog2(max_int(ENCODE_TIME, T_WINDOW) + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t                      state, state_n;
   logic [WIN_W-1:0]            win_cnt;
   logic [IDX_W-1:0]            scan_idx, best_idx, cand_idx;
   logic [CNT_W-1:0]            best_cnt, cand_cnt;
   logic [N_OUT-1:0][CNT_W-1:0] cnt;
   logic [N_OUT-1:0]            mask, neuron_en_n;
   logic                        win_end, scan_last, sample_en;
   logic                        neuron_rst_n, enc_en_n, busy_n, valid_n;

   assign win_end   = (win_cnt == '0);
   assign scan_last = (scan_idx == IDX_W'(N_OUT - 1));
   // out_spike is registered one cycle late: skip the first INTEGRATE cycle, add SAMPLE.
   assign sample_en = (state == INTEGRATE && win_cnt != WIN_W'(T_WINDOW - 1)) || state == SAMPLE;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_n;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:      if (bus.start)        state_n = CLEAR;
         CLEAR:                           state_n = ENCODE;
         ENCODE:    if (win_end)          state_n = INTEGRATE;
         INTEGRATE: if (win_end)          state_n = SAMPLE;
         SAMPLE:                          state_n = SCAN;
         SCAN:      if (scan_last)        state_n = RESULT;
         RESULT:    if (bus.result_ready) state_n = IDLE;
         default:                         state_n = IDLE;
      endcase
   end

   always_comb begin
      neuron_rst_n = (state_n == CLEAR);
      enc_en_n     = (state_n == ENCODE) || (state_n == INTEGRATE);
      neuron_en_n  = (state_n == INTEGRATE) ? ~mask : '0;
      busy_n       = (state_n != IDLE);
      valid_n      = (state_n == RESULT);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) win_cnt <= '0;
      else if (state_n != state) begin
         case (state_n)
            ENCODE:    win_cnt <= WIN_W'(ENCODE_TIME - 1);
            INTEGRATE: win_cnt <= WIN_W'(T_WINDOW - 1);
            default:   win_cnt <= '0;
         endcase
      end else if (!win_end) win_cnt <= win_cnt - 1'b1;

   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (state == CLEAR) cnt <= '0;
      else if (sample_en)
         for (int i = 0; i < N_OUT; i++)
            if (bus.out_spike[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;

   // Single shared comparator; strict '>' keeps the lowest index on ties.
   always_comb begin
      cand_cnt = best_cnt;
      cand_idx = best_idx;
      if (cnt[scan_idx] > best_cnt) begin
         cand_cnt = cnt[scan_idx];
         cand_idx = scan_idx;
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         scan_idx <= '0;
         best_idx <= '0;
         best_cnt <= '0;
      end else if (state == SAMPLE) begin
         scan_idx <= '0;
         best_idx <= '0;
         best_cnt <= '0;
      end else if (state == SCAN) begin
         best_idx <= cand_idx;
         best_cnt <= cand_cnt;
         if (!scan_last) scan_idx <= scan_idx + 1'b1;
      end

`ifdef SNN_SCHED_REFRACTORY_EN
   for (genvar i = 0; i < N_OUT; i++) begin : g_refrac
      snn_refrac_timer #(.REFRAC_CYCLES(REFRAC_CYCLES)) u_timer (
         .clk   (clk),
         .rst   (rst),
         .clear (state == CLEAR),
         .load  (sample_en && bus.out_spike[i]),
         .tick  (state == INTEGRATE),
         .mask  (mask[i])
      );
   end
`else
   assign mask = '0;
`endif

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bus.neuron_rst   <= 1'b0;
         bus.enc_en       <= 1'b0;
         bus.neuron_en    <= '0;
         bus.busy         <= 1'b0;
         bus.result_valid <= 1'b0;
         bus.winner_idx   <= '0;
         bus.winner_cnt   <= '0;
         bus.no_spike     <= 1'b0;
      end else begin
         bus.neuron_rst   <= neuron_rst_n;
         bus.enc_en       <= enc_en_n;
         bus.neuron_en    <= neuron_en_n;
         bus.busy         <= busy_n;
         bus.result_valid <= valid_n;
         if (state == SCAN && scan_last) begin
            bus.winner_idx <= cand_idx;
            bus.winner_cnt <= cand_cnt;
            bus.no_spike   <= (cand_cnt == '0);
         end
      end
endmodule

// File: tb/tb_snn_window_scheduler.sv
// Randomized bench for snn_window_scheduler against a window-level model (honours SNN_SCHED_REFRACTORY_EN).
module tb_snn_window_scheduler;
   localparam int N    = 4;
   localparam int E    = 23;
   localparam int T    = 300;
   localparam int CW   = 8;
   localparam int RF   = 50;
   localparam int R    = 2 + E + T + N;
   localparam int MAXC = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_pass = 0;
   int   n_tot  = 0;

   snn_window_scheduler_if #(.N_OUT(N), .CNT_W(CW)) bus ();

   snn_window_scheduler #(
      .N_OUT(N), .ENCODE_TIME(E), .T_WINDOW(T), .CNT_W(CW), .REFRAC_CYCLES(RF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Window model: rel = cycle index since the edge that accepted start.
   bit   m_busy = 0, m_valid = 0, m_nz = 0;
   int   rel = 0, m_idx = 0, m_cnt = 0;
   int   cnts[N];
   int   unmask[N];
   bit   e_integ;
   logic [N-1:0] e_nen;

   function automatic int arg_best(input int c[N]);
      int b = 0;
      for (int i = 1; i < N; i++) if (c[i] > c[b]) b = i;
      return b;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 0; m_valid <= 0; rel <= 0; m_idx <= 0; m_cnt <= 0; m_nz <= 0;
      end else if (!m_busy) begin
         if (bus.start) begin
            m_busy <= 1; rel <= 0;
            for (int i = 0; i < N; i++) begin cnts[i] <= 0; unmask[i] <= 0; end
         end
      end else if (m_valid) begin
         if (bus.result_ready) begin m_busy <= 0; m_valid <= 0; end
      end else begin
         if (rel >= E + 2 && rel <= E + T + 1)
            for (int i = 0; i < N; i++)
               if (bus.out_spike[i]) begin
                  if (cnts[i] < MAXC) cnts[i] <= cnts[i] + 1;
                  unmask[i] <= rel + 1 + RF;
               end
         rel <= rel + 1;
         if (rel + 1 == R) begin
            m_valid <= 1;
            m_idx   <= arg_best(cnts);
            m_cnt   <= cnts[arg_best(cnts)];
            m_nz    <= (cnts[arg_best(cnts)] == 0);
         end
      end
   end

   always_comb begin
      e_nen   = '0;
      e_integ = m_busy && !m_valid && rel >= E + 1 && rel <= E + T;
      for (int i = 0; i < N; i++) begin
`ifdef SNN_SCHED_REFRACTORY_EN
         e_nen[i] = e_integ && (rel >= unmask[i]);
`else
         e_nen[i] = e_integ;
`endif
      end
   end

   always @(negedge clk) begin
      chk("neuron_rst", bus.neuron_rst, m_busy && !m_valid && rel == 0);
      chk("enc_en", bus.enc_en, m_busy && !m_valid && rel >= 1 && rel <= E + T);
      chk("neuron_en", bus.neuron_en, e_nen);
      chk("busy", bus.busy, m_busy);
      chk("result_valid", bus.result_valid, m_valid);
      if (m_valid || rst) begin
         chk("winner_idx", bus.winner_idx, m_idx);
         chk("winner_cnt", bus.winner_cnt, m_cnt);
         chk("no_spike", bus.no_spike, m_nz);
      end
   end

   task automatic run_window(input int mode, input int dens, input int rdy_dly, input int abort_at,
                             output int lat, output int w_idx, output int w_cnt, output int w_nz,
                             output int n_rst, output int n_enc, output int n_mask0);
      int s;
      logic [N-1:0] sp;
      lat = -1; w_idx = 0; w_cnt = 0; w_nz = 0; n_rst = 0; n_enc = 0; n_mask0 = 0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int j = 0; j < R + 50; j++) begin
         if (bus.result_valid) begin lat = j; break; end
         if (j == abort_at) begin
            rst = 1'b1;
            #2;
            chk("abort_busy", bus.busy, 0);
            chk("abort_enc_en", bus.enc_en, 0);
            chk("abort_neuron_en", bus.neuron_en, 0);
            chk("abort_valid", bus.result_valid, 0);
            #10 rst = 1'b0;
            bus.out_spike = '0;
            bus.result_ready = 1'b0;
            @(posedge clk); #1;
            return;
         end
         n_rst += int'(bus.neuron_rst);
         n_enc += int'(bus.enc_en);
         if (!bus.neuron_en[0] && bus.neuron_en[1]) n_mask0++;
         s  = j - E - 2;
         sp = '0;
         case (mode)
            1: begin
               sp[2] = (s >= 0 && s < 10);
               sp[1] = (s >= 20 && s < 27);
               sp[0] = (j == E + 1) || (j == E + T + 2);
            end
            2: begin
               sp[1] = (s >= 0 && s < 5);
               sp[3] = (s >= 100 && s < 105);
            end
            3: sp[0] = 1'b1;
            4: for (int i = 0; i < N; i++) sp[i] = ($urandom_range(0, 63) < dens);
            5: sp[0] = (s == 5);
            default: sp = '0;
         endcase
         bus.out_spike    = sp;
         bus.result_ready = (mode == 4) ? 1'($urandom_range(0, 1)) : 1'b0;
         @(posedge clk); #1;
      end
      if (lat < 0) chk("valid_timeout", 0, 1);
      w_idx = int'(bus.winner_idx);
      w_cnt = int'(bus.winner_cnt);
      w_nz  = int'(bus.no_spike);
      bus.out_spike = '0;
      for (int k = 0; k < rdy_dly; k++) begin
         bus.result_ready = 1'b0;
         bus.start = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      bus.result_ready = 1'b1;
      @(posedge clk); #1;
      bus.result_ready = 1'b0;
      chk("valid_drop", bus.result_valid, 0);
      chk("idle_after_accept", bus.busy, 0);
   endtask

   initial begin
      int lat, wi, wc, wn, nr, ne, nm;
      int dl[5] = '{0, 2, 8, 32, 64};
      bus.start = 1'b0;
      bus.out_spike = '0;
      bus.result_ready = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_valid", bus.result_valid, 0);
      chk("rst_enc_en", bus.enc_en, 0);
      chk("rst_winner_cnt", bus.winner_cnt, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Silent window: 2+23+300+4 edges to valid, enc_en high 23+300 cycles.
      run_window(0, 0, 0, -1, lat, wi, wc, wn, nr, ne, nm);
      chk("lat_329", lat, 329);
      chk("enc_cycles_323", ne, 323);
      chk("neuron_rst_pulses", nr, 1);
      chk("silent_idx", wi, 0);
      chk("silent_cnt", wc, 0);
      chk("silent_no_spike", wn, 1);

      run_window(1, 0, 0, -1, lat, wi, wc, wn, nr, ne, nm);
      chk("w2_idx", wi, 2);
      chk("w2_cnt", wc, 10);
      chk("w2_no_spike", wn, 0);

      run_window(2, 0, 0, -1, lat, wi, wc, wn, nr, ne, nm);
      chk("tie_idx", wi, 1);
      chk("tie_cnt", wc, 5);

      run_window(3, 0, 0, -1, lat, wi, wc, wn, nr, ne, nm);
      chk("sat_idx", wi, 0);
      chk("sat_cnt", wc, 255);

      run_window(0, 0, 20, -1, lat, wi, wc, wn, nr, ne, nm);

      run_window(4, 16, 0, E + 50, lat, wi, wc, wn, nr, ne, nm);
      run_window(4, 16, 1, -1, lat, wi, wc, wn, nr, ne, nm);
      chk("post_abort_lat", lat, 329);

`ifdef SNN_SCHED_REFRACTORY_EN
      run_window(5, 0, 0, -1, lat, wi, wc, wn, nr, ne, nm);
      chk("refrac_mask_cycles", nm, 50);
      chk("refrac_cnt", wc, 1);
`endif

      for (int w = 0; w < 20; w++)
         run_window(4, dl[$urandom_range(0, 4)], $urandom_range(0, 4), -1,
                    lat, wi, wc, wn, nr, ne, nm);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
